// File: rtl/inst_read_matrix.sv
// Read-only AXI-Lite instruction matrix: round-robin over masters, base/mask decode
// over slaves, local DECERR for unmapped addresses, one transaction in flight.

module inst_read_matrix_dec #(
  parameter int                ADDR_W = 64,
  parameter logic [ADDR_W-1:0] BASE   = '0,
  parameter logic [ADDR_W-1:0] MASK   = '0
) (
  input  logic [ADDR_W-1:0] addr,
  output logic              hit
);
  assign hit = ((addr & MASK) == BASE);
endmodule

module inst_read_matrix #(
  parameter int NUM_MASTERS = 2,
  parameter int NUM_SLAVES  = 2,
  parameter int ADDR_W      = 64,
  parameter int DATA_W      = 64,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_BASE =
    {64'h0000_0000_8000_0000, 64'h0000_0000_0000_0000},
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_MASK =
    {64'hFFFF_FFFF_F000_0000, 64'hFFFF_FFFF_FFFF_0000}
) (
  input  logic                          ACLK,
  input  logic                          ARESETn,
  input  logic [NUM_MASTERS-1:0]        M_ARVALID,
  output logic [NUM_MASTERS-1:0]        M_ARREADY,
  input  logic [NUM_MASTERS*ADDR_W-1:0] M_ARADDR,
  input  logic [NUM_MASTERS*3-1:0]      M_ARPROT,
  output logic [NUM_MASTERS-1:0]        M_RVALID,
  input  logic [NUM_MASTERS-1:0]        M_RREADY,
  output logic [DATA_W-1:0]             M_RDATA,
  output logic [1:0]                    M_RRESP,
  output logic [NUM_SLAVES-1:0]         S_ARVALID,
  input  logic [NUM_SLAVES-1:0]         S_ARREADY,
  output logic [ADDR_W-1:0]             S_ARADDR,
  output logic [2:0]                    S_ARPROT,
  input  logic [NUM_SLAVES-1:0]         S_RVALID,
  output logic [NUM_SLAVES-1:0]         S_RREADY,
  input  logic [NUM_SLAVES*DATA_W-1:0]  S_RDATA,
  input  logic [NUM_SLAVES*2-1:0]       S_RRESP
);
  localparam int GW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int SW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam logic [NUM_SLAVES-1:0][ADDR_W-1:0] BASE_ARR = SLAVE_BASE;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, ERR} state_t;

  state_t state, state_nxt;
  logic [GW-1:0] last_grant, grant, rr_idx;
  logic [SW-1:0] sel, hit_sel;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0] prot_q;
  logic rr_found, any_req, any_hit;
  logic [NUM_SLAVES-1:0] hit;

  logic [NUM_MASTERS-1:0][ADDR_W-1:0] m_addr;
  logic [NUM_MASTERS-1:0][2:0]        m_prot;
  logic [NUM_SLAVES-1:0][DATA_W-1:0]  s_data;
  logic [NUM_SLAVES-1:0][1:0]         s_resp;
  logic [ADDR_W-1:0] req_addr;
  logic [2:0]        req_prot;

  assign m_addr = M_ARADDR;
  assign m_prot = M_ARPROT;
  assign s_data = S_RDATA;
  assign s_resp = S_RRESP;

  // Round-robin: first requester found searching upward from last_grant+1.
  always_comb begin
    logic [GW-1:0] idx;
    rr_found = 1'b0;
    rr_idx   = '0;
    idx      = '0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      idx = GW'((int'(last_grant) + i) % NUM_MASTERS);
      if (!rr_found && M_ARVALID[idx]) begin
        rr_found = 1'b1;
        rr_idx   = idx;
      end
    end
  end

  assign any_req  = |M_ARVALID;
  assign req_addr = m_addr[rr_idx];
  assign req_prot = m_prot[rr_idx];

  for (genvar s = 0; s < NUM_SLAVES; s++) begin : g_dec
    inst_read_matrix_dec #(
      .ADDR_W (ADDR_W),
      .BASE   (SLAVE_BASE[s*ADDR_W +: ADDR_W]),
      .MASK   (SLAVE_MASK[s*ADDR_W +: ADDR_W])
    ) u_dec (
      .addr (req_addr),
      .hit  (hit[s])
    );
  end

  // Overlapping windows resolve to the lowest slave index.
  always_comb begin
    hit_sel = '0;
    for (int s = NUM_SLAVES - 1; s >= 0; s--)
      if (hit[s]) hit_sel = SW'(s);
  end
  assign any_hit = |hit;

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state      <= IDLE;
      last_grant <= GW'(NUM_MASTERS - 1);
      grant      <= '0;
      sel        <= '0;
      addr_q     <= '0;
      prot_q     <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && any_req) begin
        grant      <= rr_idx;
        last_grant <= rr_idx;
        sel        <= hit_sel;
        addr_q     <= req_addr;
        prot_q     <= req_prot;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (any_req) state_nxt = any_hit ? ADDR : ERR;
      ADDR: if (S_ARREADY[sel]) state_nxt = DATA;
      DATA: if (S_RVALID[sel] && M_RREADY[grant]) state_nxt = IDLE;
      ERR:  if (M_RREADY[grant]) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    M_ARREADY = '0;
    M_RVALID  = '0;
    M_RDATA   = '0;
    M_RRESP   = '0;
    S_ARVALID = '0;
    S_ARADDR  = '0;
    S_ARPROT  = '0;
    S_RREADY  = '0;
    case (state)
      IDLE: M_ARREADY[rr_idx] = any_req & ARESETn;
      ADDR: begin
        S_ARVALID[sel] = 1'b1;
        S_ARADDR       = addr_q - BASE_ARR[sel];
        S_ARPROT       = prot_q;
      end
      DATA: begin
        M_RVALID[grant] = S_RVALID[sel];
        S_RREADY[sel]   = M_RREADY[grant];
        M_RDATA         = s_data[sel];
        M_RRESP         = s_resp[sel];
      end
      ERR: begin
        M_RVALID[grant] = 1'b1;
        M_RRESP         = 2'b11;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_inst_read_matrix.sv
// Scoreboard bench for inst_read_matrix: reactive master/slave agents driven on the
// falling edge, handshakes taken from a snapshot just before each rising edge.

module tb_inst_read_matrix;
  localparam int NM = 2, NS = 2, AW = 64, DW = 64;

  logic ACLK = 1'b0;
  logic ARESETn = 1'b0;
  logic [NM-1:0]    M_ARVALID, M_ARREADY, M_RVALID, M_RREADY;
  logic [NM*AW-1:0] M_ARADDR;
  logic [NM*3-1:0]  M_ARPROT;
  logic [DW-1:0]    M_RDATA;
  logic [1:0]       M_RRESP;
  logic [NS-1:0]    S_ARVALID, S_ARREADY, S_RVALID, S_RREADY;
  logic [AW-1:0]    S_ARADDR;
  logic [2:0]       S_ARPROT;
  logic [NS*DW-1:0] S_RDATA;
  logic [NS*2-1:0]  S_RRESP;

  always #5 ACLK = ~ACLK;

  inst_read_matrix #(.NUM_MASTERS(NM), .NUM_SLAVES(NS), .ADDR_W(AW), .DATA_W(DW)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY), .M_ARADDR(M_ARADDR), .M_ARPROT(M_ARPROT),
    .M_RVALID(M_RVALID), .M_RREADY(M_RREADY), .M_RDATA(M_RDATA), .M_RRESP(M_RRESP),
    .S_ARVALID(S_ARVALID), .S_ARREADY(S_ARREADY), .S_ARADDR(S_ARADDR), .S_ARPROT(S_ARPROT),
    .S_RVALID(S_RVALID), .S_RREADY(S_RREADY), .S_RDATA(S_RDATA), .S_RRESP(S_RRESP)
  );

  typedef struct { logic [63:0] addr; logic [2:0] prot; } req_t;
  typedef struct { logic [63:0] data; logic [1:0] resp; } rsp_t;

  req_t req_q  [NM][$];
  rsp_t exp_q  [NM][$];
  req_t exp_sa [NS][$];
  int grant_log[$], ar_cyc[$], r_cyc[$];

  int n_chk = 0, n_err = 0, cyc = 0;
  int ar_wait[NS], r_wait[NS], rr_wait[NM];
  int ar_cnt[NS], r_cnt[NS], rr_cnt[NM];
  logic [1:0]  sl_resp[NS];
  logic [63:0] sl_addr[NS];
  bit sl_pend[NS], ar_busy[NM];
  bit ovr_en = 0;
  logic [63:0] ovr_data = '0;
  int sarv_cnt = 0, beats = 0, stab_err = 0;

  logic [NM-1:0] p_marv, p_marr, p_mrv, p_mrr;
  logic [NS-1:0] p_sarv, p_sarr, p_srv, p_srr;
  logic [63:0] p_saddr, p_rdata;
  logic [2:0]  p_sprot;
  logic [1:0]  p_rresp;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] gen(input int s, input logic [63:0] a);
    return {32'hC0DE_0000 + 32'(s), a[31:0]};
  endfunction

  function automatic int decode(input logic [63:0] a, output logic [63:0] rel);
    rel = '0;
    if ((a & 64'hFFFF_FFFF_FFFF_0000) == 64'h0) begin rel = a; return 0; end
    if ((a & 64'hFFFF_FFFF_F000_0000) == 64'h8000_0000) begin rel = a - 64'h8000_0000; return 1; end
    return -1;
  endfunction

  task automatic send(input int m, input logic [63:0] a, input logic [2:0] p);
    logic [63:0] rel;
    int s;
    req_t r, sa;
    rsp_t e;
    s = decode(a, rel);
    r.addr = a; r.prot = p;
    req_q[m].push_back(r);
    if (s < 0) begin
      e.data = '0; e.resp = 2'b11;
    end else begin
      sa.addr = rel; sa.prot = p;
      exp_sa[s].push_back(sa);
      e.data = ovr_en ? ovr_data : gen(s, rel);
      e.resp = sl_resp[s];
    end
    exp_q[m].push_back(e);
  endtask

  function automatic bit busy();
    for (int m = 0; m < NM; m++)
      if (req_q[m].size() != 0 || exp_q[m].size() != 0 || ar_busy[m]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic tick();
    @(negedge ACLK);
    #2;
  endtask

  task automatic wait_done();
    int n = 0;
    while (n < 2000 && busy()) begin tick(); n++; end
    chk("drain", 64'(busy()), 64'd0);
    repeat (2) tick();
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_m_arready"}, 64'(M_ARREADY), 64'd0);
    chk({tag, "_m_rvalid"},  64'(M_RVALID),  64'd0);
    chk({tag, "_s_arvalid"}, 64'(S_ARVALID), 64'd0);
    chk({tag, "_s_rready"},  64'(S_RREADY),  64'd0);
    chk({tag, "_m_rdata"},   M_RDATA,        64'd0);
    chk({tag, "_m_rresp"},   64'(M_RRESP),   64'd0);
    chk({tag, "_s_araddr"},  S_ARADDR,       64'd0);
    chk({tag, "_s_arprot"},  64'(S_ARPROT),  64'd0);
  endtask

  // Master and slave agents.
  initial begin
    req_t r, sa;
    rsp_t e;
    M_ARVALID = '0; M_ARADDR = '0; M_ARPROT = '0; M_RREADY = '1;
    S_ARREADY = '0; S_RVALID = '0; S_RDATA = '0; S_RRESP = '0;
    {p_marv, p_marr, p_mrv, p_mrr, p_sarv, p_sarr, p_srv, p_srr} = '0;
    p_saddr = '0; p_rdata = '0; p_sprot = '0; p_rresp = '0;
    forever begin
      @(negedge ACLK);
      cyc++;
      if (!ARESETn) begin
        M_ARVALID = '0; S_ARREADY = '0; S_RVALID = '0; S_RDATA = '0; S_RRESP = '0;
        for (int m = 0; m < NM; m++) begin ar_busy[m] = 0; rr_cnt[m] = 0; end
        for (int s = 0; s < NS; s++) begin sl_pend[s] = 0; ar_cnt[s] = 0; r_cnt[s] = 0; end
      end else begin
        for (int m = 0; m < NM; m++) begin
          if (p_marv[m] && p_marr[m]) begin
            ar_busy[m] = 0; M_ARVALID[m] = 1'b0;
            grant_log.push_back(m); ar_cyc.push_back(cyc);
          end
          if (!ar_busy[m] && req_q[m].size() > 0) begin
            r = req_q[m].pop_front();
            M_ARVALID[m] = 1'b1;
            M_ARADDR[m*AW +: AW] = r.addr;
            M_ARPROT[m*3 +: 3] = r.prot;
            ar_busy[m] = 1;
          end
          if (p_mrv[m] && p_mrr[m]) begin
            beats++; r_cyc.push_back(cyc); rr_cnt[m] = 0;
            if (exp_q[m].size() == 0) chk($sformatf("unexpected_r_m%0d", m), 64'd1, 64'd0);
            else begin
              e = exp_q[m].pop_front();
              chk($sformatf("rdata_m%0d", m), p_rdata, e.data);
              chk($sformatf("rresp_m%0d", m), 64'(p_rresp), 64'(e.resp));
            end
          end else if (p_mrv[m]) rr_cnt[m]++;
          M_RREADY[m] = (rr_cnt[m] >= rr_wait[m]);
        end
        for (int s = 0; s < NS; s++) begin
          if (sl_pend[s] && p_srv[s] && p_srr[s]) begin
            sl_pend[s] = 0; S_RVALID[s] = 1'b0;
            S_RDATA[s*DW +: DW] = '0; S_RRESP[s*2 +: 2] = '0;
          end
          if (p_sarv[s] && p_sarr[s]) begin
            S_ARREADY[s] = 1'b0; ar_cnt[s] = 0; r_cnt[s] = 0;
            sl_pend[s] = 1; sl_addr[s] = p_saddr;
            if (exp_sa[s].size() == 0) chk($sformatf("unexpected_ar_s%0d", s), 64'd1, 64'd0);
            else begin
              sa = exp_sa[s].pop_front();
              chk($sformatf("s_araddr_s%0d", s), p_saddr, sa.addr);
              chk($sformatf("s_arprot_s%0d", s), 64'(p_sprot), 64'(sa.prot));
            end
          end else if (S_ARVALID[s] && !S_ARREADY[s]) begin
            if (ar_cnt[s] >= ar_wait[s]) S_ARREADY[s] = 1'b1;
            else ar_cnt[s]++;
          end
          if (sl_pend[s] && !S_RVALID[s]) begin
            if (r_cnt[s] >= r_wait[s]) begin
              S_RVALID[s] = 1'b1;
              S_RDATA[s*DW +: DW] = ovr_en ? ovr_data : gen(s, sl_addr[s]);
              S_RRESP[s*2 +: 2] = sl_resp[s];
            end else r_cnt[s]++;
          end
        end
      end
      #1;
      if (ARESETn) begin
        for (int s = 0; s < NS; s++) begin
          if (S_ARVALID[s]) sarv_cnt++;
          if (p_sarv[s] && !p_sarr[s] &&
              (!S_ARVALID[s] || S_ARADDR != p_saddr || S_ARPROT != p_sprot)) stab_err++;
        end
        for (int m = 0; m < NM; m++)
          if (p_mrv[m] && !p_mrr[m] &&
              (!M_RVALID[m] || M_RDATA != p_rdata || M_RRESP != p_rresp)) stab_err++;
      end
      p_marv = M_ARVALID; p_marr = M_ARREADY; p_mrv = M_RVALID; p_mrr = M_RREADY;
      p_sarv = S_ARVALID; p_sarr = S_ARREADY; p_srv = S_RVALID; p_srr = S_RREADY;
      p_saddr = S_ARADDR; p_sprot = S_ARPROT; p_rdata = M_RDATA; p_rresp = M_RRESP;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got %0d checks expected completion", n_chk);
    $fatal(1);
  end

  initial begin
    int n;
    int exp_g[4];
    for (int s = 0; s < NS; s++) begin ar_wait[s] = 0; r_wait[s] = 0; sl_resp[s] = 2'b00; end
    for (int m = 0; m < NM; m++) rr_wait[m] = 0;
    ARESETn = 1'b0;
    repeat (3) tick();
    chk_idle_outputs("rst");
    ARESETn = 1'b1;
    tick();

    // Zero-wait slave 1, data visible two cycles after the address handshake.
    ovr_en = 1; ovr_data = 64'hDEAD_BEEF;
    ar_cyc.delete(); r_cyc.delete();
    send(0, 64'h8000_0010, 3'b101);
    wait_done();
    if (ar_cyc.size() > 0 && r_cyc.size() > 0) chk("t1_latency", 64'(r_cyc[$] - ar_cyc[$]), 64'd2);
    else chk("t1_handshakes", 64'(r_cyc.size()), 64'd1);
    ovr_en = 0;

    // Slave wait states, master backpressure, SLVERR.
    ar_wait[1] = 4; r_wait[1] = 3; sl_resp[1] = 2'b10; rr_wait[0] = 2;
    beats = 0; stab_err = 0; ar_cyc.delete(); r_cyc.delete();
    send(0, 64'h8000_1234, 3'b110);
    wait_done();
    chk("t4_beats", 64'(beats), 64'd1);
    chk("t4_stable", 64'(stab_err), 64'd0);
    if (ar_cyc.size() > 0 && r_cyc.size() > 0) chk("t4_latency", 64'(r_cyc[$] - ar_cyc[$]), 64'd11);
    else chk("t4_handshakes", 64'(r_cyc.size()), 64'd1);
    ar_wait[1] = 0; r_wait[1] = 0; sl_resp[1] = 2'b00; rr_wait[0] = 0;

    // Unmapped address from master 1.
    sarv_cnt = 0; ar_cyc.delete(); r_cyc.delete();
    send(1, 64'h4000_0000, 3'b000);
    wait_done();
    chk("t3_no_s_arvalid", 64'(sarv_cnt), 64'd0);
    if (ar_cyc.size() > 0 && r_cyc.size() > 0) chk("t3_latency", 64'(r_cyc[$] - ar_cyc[$]), 64'd1);
    else chk("t3_handshakes", 64'(r_cyc.size()), 64'd1);

    // Both masters request back to back; last grant was master 1.
    grant_log.delete(); ar_cyc.delete();
    send(0, 64'h0000_0100, 3'b001); send(1, 64'h8000_0000, 3'b010);
    send(0, 64'h0000_0100, 3'b001); send(1, 64'h8000_0000, 3'b010);
    wait_done();
    exp_g = '{0, 1, 0, 1};
    chk("t2_ngrant", 64'(grant_log.size()), 64'd4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++)
      chk($sformatf("t2_grant%0d", i), 64'(grant_log[i]), 64'(exp_g[i]));
    for (int i = 1; i < ar_cyc.size(); i++)
      chk($sformatf("t2_gap%0d", i), 64'(ar_cyc[i] - ar_cyc[i-1]), 64'd3);

    // Reset while the slave is still producing data.
    r_wait[1] = 20;
    send(0, 64'h8000_0040, 3'b000);
    n = 0;
    while (!sl_pend[1] && n < 100) begin tick(); n++; end
    chk("t5_in_data", 64'(sl_pend[1]), 64'd1);
    ARESETn = 1'b0;
    for (int m = 0; m < NM; m++) begin exp_q[m].delete(); req_q[m].delete(); end
    for (int s = 0; s < NS; s++) exp_sa[s].delete();
    tick();
    chk_idle_outputs("t5_rst");
    ARESETn = 1'b1;
    r_wait[1] = 0;
    grant_log.delete();
    send(1, 64'h8000_0000, 3'b011); send(0, 64'h0000_0200, 3'b100);
    wait_done();
    chk("t5_ngrant", 64'(grant_log.size()), 64'd2);
    if (grant_log.size() > 0) chk("t5_first_grant", 64'(grant_log[0]), 64'd0);
    repeat (5) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/inst_read_matrix.md
# inst_read_matrix

Parametrised read-only AXI-Lite instruction bus matrix: arbitrates NUM_MASTERS read masters (instruction fetch, debug/prefetch) onto NUM_SLAVES read slaves (boot ROM, TCM, flash window). Each slave is selected by a base/mask address decode, and the forwarded address is slave-relative (address − base). Unmapped addresses are answered locally with DECERR. It supersedes the fixed single-master, single-ROM instruction matrix with round-robin arbitration, multi-slave decode and error responses, and allows one outstanding transaction at a time.

## Interface
Parameters:
- NUM_MASTERS, 2, number of read masters (≥1)
- NUM_SLAVES, 2, number of read slaves (≥1)
- ADDR_W, 64, address width
- DATA_W, 64, data width
- SLAVE_BASE, {64'h0000_0000_8000_0000, 64'h0000_0000_0000_0000}, packed NUM_SLAVES×ADDR_W base addresses, slave 0 in LSBs
- SLAVE_MASK, {64'hFFFF_FFFF_F000_0000, 64'hFFFF_FFFF_FFFF_0000}, packed NUM_SLAVES×ADDR_W decode masks

Ports (per-channel vectors packed, index 0 in LSBs):
- ACLK  in  1  clock; all logic on the rising edge
- ARESETn  in  1  reset, synchronous, active-low
- M_ARVALID / M_ARREADY  in / out  NUM_MASTERS  master read-address handshake
- M_ARADDR  in  NUM_MASTERS×ADDR_W  master addresses
- M_ARPROT  in  NUM_MASTERS×3  master protection bits
- M_RVALID / M_RREADY  out / in  NUM_MASTERS  master read-data handshake
- M_RDATA  out  DATA_W  read data, shared by all masters and qualified by M_RVALID
- M_RRESP  out  2  response: OKAY=2'b00, SLVERR=2'b10 (from slave), DECERR=2'b11
- S_ARVALID / S_ARREADY  out / in  NUM_SLAVES  slave read-address handshake
- S_ARADDR  out  ADDR_W  slave-relative address (shared)
- S_ARPROT  out  3  forwarded ARPROT (shared)
- S_RVALID / S_RREADY  in / out  NUM_SLAVES  slave read-data handshake
- S_RDATA  in  NUM_SLAVES×DATA_W  slave data
- S_RRESP  in  NUM_SLAVES×2  slave responses

## Operation
- FSM states: IDLE, ADDR, DATA, ERR.
- IDLE:
  - If any M_ARVALID is high, grant by round-robin, searching from last_grant+1 with wrap.
  - Assert M_ARREADY[grant] combinationally in that cycle.
  - Latch grant, ARADDR and ARPROT.
  - Decode hit_i = ((addr & MASK_i) == BASE_i). With multiple hits, the lowest index wins.
  - Any hit → ADDR. No hit → ERR.
  - Update last_grant.
- ADDR:
  - S_ARVALID[sel]=1, S_ARADDR = latched addr − BASE_sel (modulo 2^ADDR_W), S_ARPROT = latched prot.
  - Hold all three stable until S_ARREADY[sel]; then → DATA.
- DATA:
  - Combinational forwarding: M_RVALID[grant] = S_RVALID[sel], S_RREADY[sel] = M_RREADY[grant], M_RDATA = S_RDATA[sel], M_RRESP = S_RRESP[sel].
  - On the S_RVALID & M_RREADY handshake → IDLE.
- ERR:
  - M_RVALID[grant]=1, M_RDATA=0, M_RRESP=2'b11.
  - Hold until M_RREADY[grant]; then → IDLE.
  - No slave signal is asserted.
- Non-granted masters: M_ARREADY=0 and M_RVALID=0 at all times. Outside ADDR and DATA, all S_ARVALID and S_RREADY are 0.
- M_ARREADY is asserted only in IDLE. A request arriving while busy waits; its ARVALID must be held, per AXI.
- Signal values when not selected:
  - M_RDATA and M_RRESP are 0 outside DATA and ERR.
  - S_ARADDR and S_ARPROT are 0 outside ADDR.

## Timing
- Reset (ARESETn=0 at a rising edge):
  - state=IDLE, last_grant=NUM_MASTERS−1, so master 0 wins first.
  - All VALID/READY outputs are 0; data, address and resp outputs are 0.
- Reset mid-transaction drops the transaction. The matrix issues no response afterwards; slaves are reset by the same ARESETn.
- Latency with a zero-wait slave:
  - cycle 0: M_AR handshake
  - cycle 1: S_ARVALID & S_ARREADY
  - cycle 2: S_RVALID → M_RVALID, same cycle
  - Next M_ARREADY: cycle 3 at the earliest.
  - Throughput: 1 beat per 3 cycles.
- DECERR path: accept at cycle 0, M_RVALID at cycle 1, next accept at cycle 2 at the earliest.
- Slave wait states and master RREADY backpressure extend ADDR/DATA/ERR without limit. There is no timeout.
- Simultaneous requests from all masters: grants rotate, so each master is served once per NUM_MASTERS transactions.
- NUM_MASTERS=1: grant is constant 0.
- Address arithmetic is ADDR_W-bit unsigned with no overflow detection.

## Test plan
- Reset, then M_ARVALID[0] with ARADDR=0x8000_0010 → S_ARVALID[1] with S_ARADDR=0x10; slave returns 0xDEAD_BEEF/OKAY → M_RVALID[0]=1, M_RDATA=0xDEAD_BEEF, M_RRESP=0 on cycle 2.
- Masters 0 and 1 both request continuously; master 0 to 0x0000_0100, master 1 to 0x8000_0000 → grants go 0,1,0,1. S_ARADDR is 0x100 on slave 0 and 0x0 on slave 1.
- ARADDR=0x4000_0000 (unmapped) → M_RVALID=1 on cycle 1 with RRESP=2'b11 and RDATA=0. No S_ARVALID ever rises.
- Slave holds S_ARREADY low 4 cycles and S_RVALID low 3 cycles; master holds RREADY low 2 cycles → S_ARVALID, S_ARADDR and M_RDATA stay stable, and exactly one beat is transferred. Slave returns SLVERR → M_RRESP=2'b10.
- ARESETn driven low during DATA → next cycle all outputs are 0 and state is IDLE. A fresh request after reset is granted to master 0 and completes normally.
